// File: rtl/id_ex_pipeline_register_if.sv
// ID->EX bundle: decoded instruction from ID, hazard controls, and registered EX view.
// The master drives the ID side and hazard controls; the slave is the pipeline register.
interface id_ex_pipeline_register_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              flush;
  logic              stall;
  logic              id_valid;
  logic [1:0]        id_ALUop;
  logic [5:0]        id_func;
  logic              id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst;
  logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
  logic [REG_W-1:0]  id_rs, id_rt, id_rd;

  logic              ex_valid;
  logic [1:0]        ex_ALUop;
  logic [5:0]        ex_func;
  logic              ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst;
  logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [REG_W-1:0]  ex_rs, ex_rt, ex_rd;

  modport master (
    output flush, stall, id_valid, id_ALUop, id_func,
           id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst,
           id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_ALUop, ex_func,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst,
           ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd
  );

  modport slave (
    input  flush, stall, id_valid, id_ALUop, id_func,
           id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc, id_RegDst,
           id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_ALUop, ex_func,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_RegDst,
           ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd
  );
endinterface

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures the decoded bundle each cycle, holds on stall,
// and loads an all-zero bubble on flush or reset.
module id_ex_pipeline_register #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic                        clk,
  input logic                        rst,
  id_ex_pipeline_register_if.slave   bus
);
  logic              r_valid;
  logic [1:0]        r_ALUop;
  logic [5:0]        r_func;
  logic              r_RegWrite, r_MemRead, r_MemWrite, r_MemtoReg, r_ALUSrc, r_RegDst;
  logic [DATA_W-1:0] r_rd1, r_rd2, r_imm;
  logic [REG_W-1:0]  r_rs, r_rt, r_rd;

  // Flush outranks stall so a branch flush during a load-use stall still kills the slot;
  // bubble loads are constants, so X on id_* can never reach the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flush) begin
      r_valid    <= 1'b0;
      r_ALUop    <= 2'b00;
      r_func     <= 6'd0;
      r_RegWrite <= 1'b0;
      r_MemRead  <= 1'b0;
      r_MemWrite <= 1'b0;
      r_MemtoReg <= 1'b0;
      r_ALUSrc   <= 1'b0;
      r_RegDst   <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
    end else if (!bus.stall) begin
      r_valid    <= bus.id_valid;
      r_ALUop    <= bus.id_ALUop;
      r_func     <= bus.id_func;
      r_RegWrite <= bus.id_RegWrite;
      r_MemRead  <= bus.id_MemRead;
      r_MemWrite <= bus.id_MemWrite;
      r_MemtoReg <= bus.id_MemtoReg;
      r_ALUSrc   <= bus.id_ALUSrc;
      r_RegDst   <= bus.id_RegDst;
      r_rd1      <= bus.id_rd1;
      r_rd2      <= bus.id_rd2;
      r_imm      <= bus.id_imm;
      r_rs       <= bus.id_rs;
      r_rt       <= bus.id_rt;
      r_rd       <= bus.id_rd;
    end
  end

  assign bus.ex_valid    = r_valid;
  assign bus.ex_ALUop    = r_ALUop;
  assign bus.ex_func     = r_func;
  assign bus.ex_RegWrite = r_RegWrite;
  assign bus.ex_MemRead  = r_MemRead;
  assign bus.ex_MemWrite = r_MemWrite;
  assign bus.ex_MemtoReg = r_MemtoReg;
  assign bus.ex_ALUSrc   = r_ALUSrc;
  assign bus.ex_RegDst   = r_RegDst;
  assign bus.ex_rd1      = r_rd1;
  assign bus.ex_rd2      = r_rd2;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_rs       = r_rs;
  assign bus.ex_rt       = r_rt;
  assign bus.ex_rd       = r_rd;
endmodule
